// File: rtl/f_fetch.sv
// Instruction fetch stage: single-outstanding request engine feeding a 1-entry
// output buffer. Optional macro F_ALIGN_CHECK_EN word-aligns redirect targets.
module f_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;
  logic        r_out_valid;
  logic [31:0] w_target_pc;
  logic        w_consume;
  logic        w_req;
  logic        w_load;

`ifdef F_ALIGN_CHECK_EN
  assign w_target_pc = redirect_pc & ~32'h0000_0003;
`else
  assign w_target_pc = redirect_pc;
`endif

  assign w_consume = r_out_valid && !stall_in && !redirect;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a redirect that races a grant must drain the stale response
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_next = imem_gnt ? S_DRAIN : S_REQ;
        end else if (w_req && imem_gnt) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_next = S_REQ;
        end else if (redirect) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          w_next = S_REQ;
        end
      end
      default: w_next = S_REQ;
    endcase
  end

  // Output logic
  always_comb begin
    w_req  = 1'b0;
    w_load = 1'b0;
    unique case (r_state)
      S_REQ:   w_req  = !reset && (!r_out_valid || w_consume) && !redirect;
      S_WAIT:  w_load = imem_rvalid && !redirect;
      S_DRAIN: w_load = 1'b0;
      default: w_req  = 1'b0;
    endcase
  end

  // Fetch PC and output buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_out_pc    <= RESET_PC;
      r_out_instr <= '0;
      r_out_valid <= 1'b0;
    end else if (redirect) begin
      r_pc        <= w_target_pc;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_instr <= imem_rdata;
      r_out_pc    <= r_pc;
      r_out_valid <= 1'b1;
      r_pc        <= r_pc + 32'd4;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign out_pc    = r_out_pc;
  assign out_instr = r_out_instr;
  assign out_valid = r_out_valid;

endmodule
